pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 163 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, flush-to-bubble and an
// optional two-entry skid buffer that lets in_ready come straight from a flop.
module pipe_stage_reg #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 32,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter int                SKID        = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    generate
        if (SKID != 0) begin : gen_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_HOLD  = 2'd1,
                ST_FULL  = 2'd2
            } state_t;

            state_t            state_reg;
            state_t            state_next;
            logic              in_ready_reg;
            logic [DATA_W-1:0] m_data_reg;
            logic [CTRL_W-1:0] m_ctrl_reg;
            logic [DATA_W-1:0] s_data_reg;
            logic [CTRL_W-1:0] s_ctrl_reg;
            logic              acc;
            logic              dep;

            assign acc = in_valid && in_ready_reg && !flush;
            assign dep = (state_reg != ST_EMPTY) && out_ready;

            // in_ready is precomputed from the next state so it is a plain flop output.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg    <= ST_EMPTY;
                    in_ready_reg <= 1'b1;
                end else begin
                    state_reg    <= state_next;
                    in_ready_reg <= (state_next != ST_FULL);
                end
            end

            always_comb begin
                state_next = state_reg;
                if (flush) begin
                    state_next = ST_EMPTY;
                end else begin
                    case (state_reg)
                        ST_EMPTY: if (acc) state_next = ST_HOLD;
                        ST_HOLD: begin
                            if (acc && !dep)      state_next = ST_FULL;
                            else if (!acc && dep) state_next = ST_EMPTY;
                        end
                        ST_FULL:  if (dep) state_next = ST_HOLD;
                        default:  state_next = ST_EMPTY;
                    endcase
                end
            end

            // Vacated entries are cleared so an empty stage never shows stale payload.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    m_data_reg <= '0;
                    m_ctrl_reg <= CTRL_BUBBLE;
                    s_data_reg <= '0;
                    s_ctrl_reg <= CTRL_BUBBLE;
                end else if (flush) begin
                    m_data_reg <= '0;
                    m_ctrl_reg <= CTRL_BUBBLE;
                    s_data_reg <= '0;
                    s_ctrl_reg <= CTRL_BUBBLE;
                end else begin
                    case (state_reg)
                        ST_EMPTY: begin
                            if (acc) begin
                                m_data_reg <= in_data;
                                m_ctrl_reg <= in_ctrl;
                            end
                        end
                        ST_HOLD: begin
                            if (acc && dep) begin
                                m_data_reg <= in_data;
                                m_ctrl_reg <= in_ctrl;
                            end else if (acc) begin
                                s_data_reg <= in_data;
                                s_ctrl_reg <= in_ctrl;
                            end else if (dep) begin
                                m_data_reg <= '0;
                                m_ctrl_reg <= CTRL_BUBBLE;
                            end
                        end
                        ST_FULL: begin
                            if (dep) begin
                                m_data_reg <= s_data_reg;
                                m_ctrl_reg <= s_ctrl_reg;
                                s_data_reg <= '0;
                                s_ctrl_reg <= CTRL_BUBBLE;
                            end
                        end
                        default: begin
                            m_data_reg <= '0;
                            m_ctrl_reg <= CTRL_BUBBLE;
                        end
                    endcase
                end
            end

            always_comb begin
                in_ready  = in_ready_reg;
                out_valid = (state_reg != ST_EMPTY);
                out_data  = m_data_reg;
                out_ctrl  = m_ctrl_reg;
                occupancy = state_reg;
            end
        end else begin : gen_single
            logic              m_valid_reg;
            logic [DATA_W-1:0] m_data_reg;
            logic [CTRL_W-1:0] m_ctrl_reg;
            logic              acc;
            logic              dep;

            assign acc = in_valid && in_ready && !flush;
            assign dep = m_valid_reg && out_ready;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    m_valid_reg <= 1'b0;
                    m_data_reg  <= '0;
                    m_ctrl_reg  <= CTRL_BUBBLE;
                end else if (flush || (dep && !acc)) begin
                    m_valid_reg <= 1'b0;
                    m_data_reg  <= '0;
                    m_ctrl_reg  <= CTRL_BUBBLE;
                end else if (acc) begin
                    m_valid_reg <= 1'b1;
                    m_data_reg  <= in_data;
                    m_ctrl_reg  <= in_ctrl;
                end
            end

            always_comb begin
                in_ready  = !m_valid_reg || out_ready;
                out_valid = m_valid_reg;
                out_data  = m_data_reg;
                out_ctrl  = m_ctrl_reg;
                occupancy = {1'b0, m_valid_reg};
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance driven by directed vector
// tables, hand-written corner sequences and a randomised scoreboard run.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset_n;

    logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] in_data1, in_ctrl1, out_data1, out_ctrl1;
    logic [1:0]  occ1;

    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [31:0] in_data0, in_ctrl0, out_data0, out_ctrl0;
    logic [1:0]  occ0;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(32), .CTRL_BUBBLE(32'h0000_0002), .SKID(1)) u_skid (
        .clk(clk), .reset_n(reset_n), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_ctrl(in_ctrl1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_ctrl(out_ctrl1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(32), .CTRL_BUBBLE(32'h0000_0002), .SKID(0)) u_single (
        .clk(clk), .reset_n(reset_n), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ctrl(in_ctrl0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_ctrl(out_ctrl0), .occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  occ;
        logic        ir;
    } vec_t;

    vec_t v1[$];
    vec_t v0[$];

    function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                                input logic fl, input logic ov, input logic [31:0] od,
                                input logic [1:0] occ, input logic ir);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Control is always driven as data+0x1000 so the expected control follows from the data.
    function automatic logic [31:0] exp_ctrl(input logic ov, input logic [31:0] od);
        return ov ? (od + 32'h1000) : 32'h0000_0002;
    endfunction

    task automatic check_out1(input string tag, input logic ov, input logic [31:0] od,
                              input logic [1:0] occ, input logic ir);
        chk({tag, ".out_valid"}, {31'd0, out_valid1}, {31'd0, ov});
        chk({tag, ".out_data"}, out_data1, od);
        chk({tag, ".out_ctrl"}, out_ctrl1, exp_ctrl(ov, od));
        chk({tag, ".occupancy"}, {30'd0, occ1}, {30'd0, occ});
        chk({tag, ".in_ready"}, {31'd0, in_ready1}, {31'd0, ir});
    endtask

    task automatic check_out0(input string tag, input logic ov, input logic [31:0] od,
                              input logic [1:0] occ, input logic ir);
        chk({tag, ".out_valid"}, {31'd0, out_valid0}, {31'd0, ov});
        chk({tag, ".out_data"}, out_data0, od);
        chk({tag, ".out_ctrl"}, out_ctrl0, exp_ctrl(ov, od));
        chk({tag, ".occupancy"}, {30'd0, occ0}, {30'd0, occ});
        chk({tag, ".in_ready"}, {31'd0, in_ready0}, {31'd0, ir});
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] seq;
        logic        acc;
        logic        dep;

        reset_n    = 1'b0;
        in_valid1  = 1'b1; in_data1 = 32'hDEAD_BEEF; in_ctrl1 = 32'hDEAD_BEEF + 32'h1000;
        out_ready1 = 1'b0; flush1 = 1'b0;
        in_valid0  = 1'b1; in_data0 = 32'hDEAD_BEEF; in_ctrl0 = 32'hDEAD_BEEF + 32'h1000;
        out_ready0 = 1'b0; flush0 = 1'b0;

        // Directed table for the skid instance, starting from the state right after reset.
        v1.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'd1, 1'b1));
        v1.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1));
        v1.push_back(mk(1'b1, 32'h1,  1'b1, 1'b0, 1'b1, 32'h1,  2'd1, 1'b1));
        v1.push_back(mk(1'b1, 32'h2,  1'b1, 1'b0, 1'b1, 32'h2,  2'd1, 1'b1));
        v1.push_back(mk(1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 32'h3,  2'd1, 1'b1));
        v1.push_back(mk(1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 32'h4,  2'd1, 1'b1));
        v1.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h4,  2'd1, 1'b1));
        v1.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1));
        v1.push_back(mk(1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 32'hA,  2'd1, 1'b1));
        v1.push_back(mk(1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 32'hA,  2'd2, 1'b0));
        for (int i = 0; i < 4; i++)
            v1.push_back(mk(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0));
        v1.push_back(mk(1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 32'hB,  2'd1, 1'b1));
        v1.push_back(mk(1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 32'hC,  2'd1, 1'b1));
        v1.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1));
        v1.push_back(mk(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1));
        v1.push_back(mk(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b0));
        v1.push_back(mk(1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 1'b1));
        v1.push_back(mk(1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h33, 2'd1, 1'b1));
        v1.push_back(mk(1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 32'h0,  2'd0, 1'b1));
        v1.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1));
        v1.push_back(mk(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 32'h44, 2'd1, 1'b1));
        v1.push_back(mk(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h44, 2'd2, 1'b0));

        // Single-entry instance: in_ready is checked with the row's out_ready still applied.
        v0.push_back(mk(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h10, 2'd1, 1'b0));
        v0.push_back(mk(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 32'h10, 2'd1, 1'b0));
        v0.push_back(mk(1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 32'h20, 2'd1, 1'b1));
        v0.push_back(mk(1'b1, 32'h30, 1'b1, 1'b0, 1'b1, 32'h30, 2'd1, 1'b1));
        v0.push_back(mk(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 2'd1, 1'b1));
        v0.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1));
        v0.push_back(mk(1'b1, 32'h50, 1'b0, 1'b0, 1'b1, 32'h50, 2'd1, 1'b0));
        v0.push_back(mk(1'b1, 32'h60, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 1'b1));
        v0.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1));

        // Reset held across clock edges with a live input must keep both stages empty.
        repeat (2) @(posedge clk);
        #1;
        check_out1("reset.skid", 1'b0, 32'h0, 2'd0, 1'b1);
        check_out0("reset.single", 1'b0, 32'h0, 2'd0, 1'b1);
        in_valid0 = 1'b0;
        reset_n   = 1'b1;

        for (int i = 0; i < v1.size(); i++) begin
            in_valid1 = v1[i].iv; in_data1 = v1[i].d; in_ctrl1 = v1[i].d + 32'h1000;
            out_ready1 = v1[i].ordy; flush1 = v1[i].fl;
            @(posedge clk);
            #1;
            check_out1($sformatf("skid_row%0d", i), v1[i].ov, v1[i].od, v1[i].occ, v1[i].ir);
            $display("skid row %0d: iv=%0b d=%h ordy=%0b fl=%0b -> ov=%0b od=%h occ=%0d ir=%0b",
                     i, v1[i].iv, v1[i].d, v1[i].ordy, v1[i].fl,
                     out_valid1, out_data1, occ1, in_ready1);
        end

        // Stage is FULL here; an asynchronous reset must clear it before the next edge.
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_out1("async_reset", 1'b0, 32'h0, 2'd0, 1'b1);
        $display("async reset mid-cycle: ov=%0b occ=%0d ir=%0b", out_valid1, occ1, in_ready1);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Randomised handshake against a reference queue of at most two entries.
        seq = 32'h100;
        for (int c = 0; c < 400; c++) begin
            in_valid1  = ($urandom_range(0, 3) != 0);
            out_ready1 = ($urandom_range(0, 1) == 1);
            in_data1   = seq;
            in_ctrl1   = seq + 32'h1000;
            acc = in_valid1 && (q.size() < 2);
            dep = (q.size() > 0) && out_ready1;
            @(posedge clk);
            #1;
            if (dep) void'(q.pop_front());
            if (acc) begin
                q.push_back(seq);
                seq = seq + 32'd1;
            end
            if (q.size() > 0)
                check_out1($sformatf("rand%0d", c), 1'b1, q[0], 2'(q.size()), (q.size() < 2));
            else
                check_out1($sformatf("rand%0d", c), 1'b0, 32'h0, 2'd0, 1'b1);
        end
        $display("random run: %0d entries accepted, %0d still held", seq - 32'h100, q.size());
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_out1("drain", 1'b0, 32'h0, 2'd0, 1'b1);

        for (int i = 0; i < v0.size(); i++) begin
            in_valid0 = v0[i].iv; in_data0 = v0[i].d; in_ctrl0 = v0[i].d + 32'h1000;
            out_ready0 = v0[i].ordy; flush0 = v0[i].fl;
            @(posedge clk);
            #1;
            check_out0($sformatf("single_row%0d", i), v0[i].ov, v0[i].od, v0[i].occ, v0[i].ir);
            $display("single row %0d: iv=%0b d=%h ordy=%0b fl=%0b -> ov=%0b od=%h occ=%0d ir=%0b",
                     i, v0[i].iv, v0[i].d, v0[i].ordy, v0[i].fl,
                     out_valid0, out_data0, occ0, in_ready0);
        end

        // Combinational in_ready of the single-entry stage tracks out_ready within the cycle.
        in_valid0 = 1'b1; in_data0 = 32'h70; in_ctrl0 = 32'h1070; out_ready0 = 1'b0; flush0 = 1'b0;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        #1 chk("single.ready_follows_hi", {31'd0, in_ready0}, 32'd1);
        out_ready0 = 1'b0;
        #1 chk("single.ready_follows_lo", {31'd0, in_ready0}, 32'd0);
        chk("single.stall_data", out_data0, 32'h70);
        $display("single comb ready: held=%h ir=%0b", out_data0, in_ready0);
        out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        check_out0("single.drain", 1'b0, 32'h0, 2'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
